bit_splitter_n: RTL
===================

Name: bit_splitter_n

Overview:
Parametrised serial-to-parallel bit splitter for the PSK modulator chain. It groups an incoming serial bit stream into BITS_PER_SYM-bit symbols: 2 for QPSK I/Q, 3 for 8-PSK, and so on. It also generates a symbol-rate toggle, which is the generalisation of the divide-by-2 T flip-flop used by the QPSK splitter. It sits between the data source and the symbol mapper.

Parameters:
BITS_PER_SYM, 2, bits per output symbol; legal range is 2 to 8.
MSB_FIRST, 1, 1 = first received bit lands in sym[BITS_PER_SYM-1]; 0 = first received bit lands in sym[0].
CW, $clog2(BITS_PER_SYM), width of bit_cnt (local parameter, not overridable).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 clears all state).
din  input  1  serial data bit.
din_valid  input  1  bit strobe; din is sampled only when this is 1.
sync  input  1  synchronous symbol-alignment strobe; discards any partial symbol.
sym  output  BITS_PER_SYM  last completed symbol; held until the next symbol completes.
sym_valid  output  1  one-cycle pulse, high in the cycle in which sym carries a new value.
sym_tgl  output  1  toggles once per completed symbol (symbol-rate clock, 50% duty under steady input).
bit_cnt  output  CW  number of bits of the current partial symbol collected so far (0 to BITS_PER_SYM-1).

Behaviour:
- Reset (reset=0, asynchronous): sym=0, sym_valid=0, sym_tgl=0, bit_cnt=0, internal shift register=0.
- Reset release is synchronous to clk; the first sampled bit is on the first rising edge with reset=1.
- Bit capture (din_valid=1, sync=0):
  - MSB_FIRST=1: shift <= {shift[N-2:0], din}.
  - MSB_FIRST=0: shift <= {din, shift[N-1:1]}.
  - bit_cnt increments.
- Symbol completion: on the edge where din_valid=1 and bit_cnt==BITS_PER_SYM-1:
  - sym <= the completed word, including the current din.
  - sym_valid <= 1, sym_tgl <= ~sym_tgl, bit_cnt <= 0, shift <= 0.
- Latency: sym/sym_valid update on the same edge that captures the last bit, i.e. they are visible 1 cycle after the final din_valid cycle.
- sym_valid is 0 in every cycle without a completion. Back-to-back completions are possible only when BITS_PER_SYM cycles elapse between them.
- din_valid=0: no state changes except sym_valid<=0. Gaps of any length are allowed inside a symbol and do not lose bits.
- sync=1, din_valid=0: bit_cnt<=0, shift<=0, no completion. sym and sym_tgl are unchanged; sym_valid<=0.
- sync=1, din_valid=1: the partial symbol is discarded and din becomes bit 1 of the new symbol (bit_cnt<=1). A symbol is never emitted in a sync cycle, even if bit_cnt==BITS_PER_SYM-1.
- Counter never exceeds BITS_PER_SYM-1. For non-power-of-2 BITS_PER_SYM, unused bit_cnt codes are unreachable.
- Reset mid-symbol: the partial symbol is lost and all outputs return to their reset values immediately (asynchronous).
- No backpressure: the downstream block must accept sym when sym_valid=1.

Test Plan:
- N=2, MSB_FIRST=1, din_valid held 1, bits 1,0,1,1 -> sym=2'b10 with sym_valid=1 one cycle after bit 2; sym=2'b11 with sym_valid=1 one cycle after bit 4; sym_tgl 0->1->0; bit_cnt sequence 0,1,0,1,0.
- N=2, MSB_FIRST=0, bits 1,0 -> sym=2'b01; sym_valid is a single-cycle pulse; sym holds 2'b01 with sym_valid=0 afterwards.
- N=4, MSB_FIRST=1, bits 1,1,0,1 with din_valid=0 for 3 cycles between bit 2 and bit 3 -> exactly one sym_valid pulse, after bit 4, with sym=4'b1101; bit_cnt holds 2 during the gap.
- N=3, bits 1,1 then sync=1 with din_valid=1, din=0, then bits 1,1 -> no symbol from the first two bits; sym=3'b011 one cycle after the last bit; sym_tgl toggles once.
- N=2, continuous random bits, 1000 symbols -> every sym matches a reference model; sym_tgl period = 4 clk cycles.
- Assert reset=0 asynchronously mid-cycle while bit_cnt=1 -> sym, sym_valid, sym_tgl and bit_cnt are 0 before the next edge. After release, bits 0,1 give sym=2'b01 (MSB_FIRST=1) with no stale bit.

Source files
------------

// File: rtl/bit_splitter_n.sv
// Serial-to-parallel bit splitter: packs a strobed serial bit stream into
// BITS_PER_SYM-bit symbols and produces a symbol-rate toggle.
module bit_splitter_n #(
  parameter  int unsigned BITS_PER_SYM = 2,
  parameter  bit          MSB_FIRST    = 1'b1,
  localparam int unsigned CW           = $clog2(BITS_PER_SYM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    sync,
  output logic [BITS_PER_SYM-1:0] sym,
  output logic                    sym_valid,
  output logic                    sym_tgl,
  output logic [CW-1:0]           bit_cnt
);

  localparam logic [CW-1:0] LAST_CNT = CW'(BITS_PER_SYM - 1);

  logic [BITS_PER_SYM-1:0] shift_q, shift_d;
  logic [BITS_PER_SYM-1:0] sym_q, sym_d;
  logic                    sym_valid_q, sym_valid_d;
  logic                    sym_tgl_q, sym_tgl_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] shift_base;
  logic [BITS_PER_SYM-1:0] shift_ins;

  // A sync cycle starts from an empty register, so a bit sampled with sync
  // becomes bit 1 of a fresh symbol.
  always_comb begin
    shift_base = sync ? '0 : shift_q;
    if (MSB_FIRST) shift_ins = {shift_base[BITS_PER_SYM-2:0], din};
    else           shift_ins = {din, shift_base[BITS_PER_SYM-1:1]};
  end

  always_comb begin
    shift_d     = shift_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    sym_tgl_d   = sym_tgl_q;
    cnt_d       = cnt_q;
    if (din_valid) begin
      if (!sync && cnt_q == LAST_CNT) begin
        sym_d       = shift_ins;
        sym_valid_d = 1'b1;
        sym_tgl_d   = ~sym_tgl_q;
        cnt_d       = '0;
        shift_d     = '0;
      end else begin
        shift_d = shift_ins;
        cnt_d   = sync ? CW'(1) : cnt_q + CW'(1);
      end
    end else if (sync) begin
      shift_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_tgl_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      shift_q     <= shift_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_tgl_q   <= sym_tgl_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sym       = sym_q;
  assign sym_valid = sym_valid_q;
  assign sym_tgl   = sym_tgl_q;
  assign bit_cnt   = cnt_q;

endmodule
